apb_arbiter_rr: RTL
===================

Name: apb_arbiter_rr

Overview:
- Round-robin arbiter that shares one APB master port between MASTER_PORTS core-side APB masters.
- Sits between the cores and the APB address-decode interconnect; its M_* side drives the interconnect's single-master S_* port.
- Registers the grant and locks it for a whole SETUP/ACCESS transfer, regenerating clean APB phases downstream.
- Returns PREADY/PRDATA only to the granted core.

Parameters:
- BUS_WIDTH, 16, address/data width.
- MASTER_PORTS, 4, number of requesting cores (1..16).
- GNT_W, $clog2(MASTER_PORTS) (min 1), width of grant index; localparam.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- S_PADDR  input  MASTER_PORTS*BUS_WIDTH  per-core address.
- S_PWRITE  input  MASTER_PORTS  per-core write strobe.
- S_PSELx  input  MASTER_PORTS  per-core request (PSEL).
- S_PENABLE  input  MASTER_PORTS  per-core PENABLE; ignored, phases regenerated.
- S_PWDATA  input  MASTER_PORTS*BUS_WIDTH  per-core write data.
- S_PRDATA  output  MASTER_PORTS*BUS_WIDTH  read data; only the granted slice is non-zero.
- S_PREADY  output  MASTER_PORTS  completion pulse to the granted core.
- M_PADDR  output  BUS_WIDTH  granted address.
- M_PWRITE  output  1  granted write.
- M_PSEL  output  1  transfer active; feeds interconnect PSEL.
- M_PENABLE  output  1  ACCESS phase.
- M_PWDATA  output  BUS_WIDTH  granted write data.
- M_PRDATA  input  BUS_WIDTH  read data from interconnect.
- M_PREADY  input  1  completion from interconnect.
- M_GRANT  output  GNT_W  current or last grant index, for debug/trace.

Behaviour:
- Core contract: a core raises S_PSELx[i] and holds address, write and data stable until it sees S_PREADY[i]=1.
- FSM states: IDLE, SETUP, ACCESS. State, grant and last-grant pointer are registered.
- IDLE:
  - If any S_PSELx bit is set, pick the first set bit searching upward from last+1, wrapping modulo MASTER_PORTS.
  - Register it as grant and go to SETUP. Otherwise stay in IDLE.
- SETUP: M_PSEL=1, M_PENABLE=0, exactly 1 cycle, then ACCESS. M_PREADY is ignored in SETUP.
- ACCESS: M_PSEL=1, M_PENABLE=1.
  - While M_PREADY=0: hold.
  - When M_PREADY=1 (same cycle, combinationally): S_PREADY[grant]=1 and S_PRDATA slice = M_PRDATA. On the next edge: last<=grant, go to IDLE.
- M_PADDR, M_PWRITE, M_PWDATA are muxed from the registered grant. They are 0 in IDLE.
- Latency: request seen in IDLE at cycle 0 → SETUP at cycle 1 → ACCESS at cycle 2. With a zero-wait slave, S_PREADY is at cycle 2. One IDLE bubble occurs between back-to-back transfers.
- Fairness: a core that has just been served has lowest priority next arbitration. Each of N continuously requesting cores is served within N transfers.
- Request dropped mid-transfer (protocol violation): the transfer still completes downstream and S_PREADY still pulses. It is not aborted.
- MASTER_PORTS=1: the grant is always 0 and behaviour is otherwise identical.
- Reset, asserted at any time including mid-ACCESS:
  - Immediately: state=IDLE, grant=0, last=MASTER_PORTS-1 (core 0 wins first), M_GRANT=0.
  - All M_* outputs 0, all S_PREADY and S_PRDATA 0.
  - A downstream transfer in flight is abandoned.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - A wait counter of width 8 counts ACCESS cycles with M_PREADY=0.
  - When it reaches ARB_TIMEOUT_CYCLES (default 255), the arbiter forces S_PREADY[grant]=1 with S_PRDATA slice=16'hDEAD for 1 cycle, drops M_PSEL/M_PENABLE and returns to IDLE.
  - The counter clears on entry to SETUP and on reset.
  - Prints $display("apb_arb timeout core %0d", grant) in simulation.
- Undefined: the counter is absent and ACCESS waits indefinitely for M_PREADY.

Decomposition:
- In vmicro16_soc_config.v: FSM state encodings (ARB_IDLE, ARB_SETUP, ARB_ACCESS), ARB_TIMEOUT_CYCLES, ARB_TIMEOUT_DATA (16'hDEAD), APB_ARB_TIMEOUT_EN switch.
- Sub-module rr_pick: combinational round-robin first-set search.
  - Inputs: req[MASTER_PORTS], last[GNT_W].
  - Outputs: idx[GNT_W], any.
  - Instantiated once.

Test Plan:
- Reset, then core 0 writes 0x1234 to 0x00A0 with a zero-wait slave → SETUP at cycle 1, ACCESS at cycle 2, S_PREADY[0] at cycle 2, M_PADDR=0x00A0, M_PWDATA=0x1234, M_GRANT=0.
- Cores 0–3 request simultaneously and continuously → grant order 0,1,2,3,0; S_PREADY never reaches an ungranted core.
- Core 2 reads 0x0085 while the slave holds M_PREADY=0 for 3 cycles, returning 0xBEEF → ACCESS lasts 4 cycles; S_PRDATA[47:32]=0xBEEF on the S_PREADY cycle; other slices 0.
- Reset asserted mid-ACCESS → next sampled cycle shows IDLE with all outputs 0; the first post-reset grant goes to core 0 even if cores 0 and 3 both request.
- With APB_ARB_TIMEOUT_EN defined and M_PREADY stuck at 0 → after 255 ACCESS cycles S_PREADY[grant]=1 and data=0xDEAD, then IDLE, and the next requester is served.

Source files
------------

// File: rtl/apb_arbiter_rr_pkg.sv
// Shared FSM encoding and timeout constants for the apb_arbiter_rr slice.
// The timeout logic is compiled in only when APB_ARB_TIMEOUT_EN is defined.
package apb_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SETUP,
    ARB_ACCESS
  } arb_state_t;

  localparam int unsigned ARB_TIMEOUT_CYCLES = 255;
  localparam logic [15:0] ARB_TIMEOUT_DATA   = 16'hDEAD;

  function automatic int unsigned gnt_width(input int unsigned ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/apb_arbiter_rr_if.sv
// Core-side (S_*) and interconnect-side (M_*) APB signals of the arbiter.
// slave: arbiter view; master: view of the cores plus the downstream interconnect.
interface apb_arbiter_rr_if import apb_arbiter_rr_pkg::*; #(
  parameter int unsigned BUS_WIDTH    = 16,
  parameter int unsigned MASTER_PORTS = 4
);
  localparam int unsigned GNT_W = gnt_width(MASTER_PORTS);

  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR;
  logic [MASTER_PORTS-1:0]           S_PWRITE;
  logic [MASTER_PORTS-1:0]           S_PSELx;
  logic [MASTER_PORTS-1:0]           S_PENABLE;
  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA;
  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA;
  logic [MASTER_PORTS-1:0]           S_PREADY;

  logic [BUS_WIDTH-1:0] M_PADDR;
  logic                 M_PWRITE;
  logic                 M_PSEL;
  logic                 M_PENABLE;
  logic [BUS_WIDTH-1:0] M_PWDATA;
  logic [BUS_WIDTH-1:0] M_PRDATA;
  logic                 M_PREADY;
  logic [GNT_W-1:0]     M_GRANT;

  modport slave (
    input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
    output S_PRDATA, S_PREADY,
    output M_PADDR, M_PWRITE, M_PSEL, M_PENABLE, M_PWDATA, M_GRANT,
    input  M_PRDATA, M_PREADY
  );

  modport master (
    output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
    input  S_PRDATA, S_PREADY,
    input  M_PADDR, M_PWRITE, M_PSEL, M_PENABLE, M_PWDATA, M_GRANT,
    output M_PRDATA, M_PREADY
  );

endinterface

// File: rtl/apb_arbiter_rr_rr_pick.sv
// Round-robin first-set search: lowest request above 'last', else lowest request overall.
module rr_pick #(
  parameter int unsigned MASTER_PORTS = 4,
  parameter int unsigned GNT_W        = 2
) (
  input  logic [MASTER_PORTS-1:0] req,
  input  logic [GNT_W-1:0]        last,
  output logic [GNT_W-1:0]        idx,
  output logic                    any
);

  logic found_hi;
  logic found_lo;

  // Two passes replace a wrapping search: the upper pass covers last+1..top,
  // the lower pass supplies the wrapped winner when nothing above was found.
  always_comb begin
    idx      = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int unsigned i = 0; i < MASTER_PORTS; i++) begin
      if (!found_hi && (GNT_W'(i) > last) && req[i]) begin
        idx      = GNT_W'(i);
        found_hi = 1'b1;
      end
    end
    for (int unsigned i = 0; i < MASTER_PORTS; i++) begin
      if (!found_hi && !found_lo && req[i]) begin
        idx      = GNT_W'(i);
        found_lo = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/apb_arbiter_rr.sv
// Round-robin arbiter sharing one APB master port between MASTER_PORTS cores.
// Define APB_ARB_TIMEOUT_EN to force-complete transfers stuck in ACCESS.
module apb_arbiter_rr import apb_arbiter_rr_pkg::*; #(
  parameter int unsigned BUS_WIDTH    = 16,
  parameter int unsigned MASTER_PORTS = 4
) (
  input logic             clk,
  input logic             reset,
  apb_arbiter_rr_if.slave bus
);

  localparam int unsigned GNT_W = gnt_width(MASTER_PORTS);

  arb_state_t       state, state_nxt;
  logic [GNT_W-1:0] grant, grant_nxt;
  logic [GNT_W-1:0] last, last_nxt;
  logic [GNT_W-1:0] pick_idx;
  logic             pick_any;
  logic             done;
  logic             timeout;
  logic             unused_penable;

  // Core PENABLE carries no information: phases are regenerated downstream.
  assign unused_penable = ^bus.S_PENABLE;

  rr_pick #(
    .MASTER_PORTS(MASTER_PORTS),
    .GNT_W       (GNT_W)
  ) u_pick (
    .req (bus.S_PSELx),
    .last(last),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout = (state == ARB_ACCESS) && !bus.M_PREADY &&
                   (wait_cnt == 8'(ARB_TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state_nxt == ARB_SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ARB_ACCESS) && !bus.M_PREADY && !timeout) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && timeout) $display("apb_arb timeout core %0d", grant);
  end
`endif
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB_IDLE;
      grant <= '0;
      last  <= GNT_W'(MASTER_PORTS - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    last_nxt      = last;
    done          = 1'b0;
    bus.M_PSEL    = 1'b0;
    bus.M_PENABLE = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_idx;
          state_nxt = ARB_SETUP;
        end
      end
      ARB_SETUP: begin
        bus.M_PSEL = 1'b1;
        state_nxt  = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        bus.M_PSEL    = !timeout;
        bus.M_PENABLE = !timeout;
        if (bus.M_PREADY || timeout) begin
          done      = 1'b1;
          last_nxt  = grant;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.M_PADDR  = '0;
    bus.M_PWRITE = 1'b0;
    bus.M_PWDATA = '0;
    bus.S_PREADY = '0;
    bus.S_PRDATA = '0;
    for (int unsigned i = 0; i < MASTER_PORTS; i++) begin
      if ((state != ARB_IDLE) && (GNT_W'(i) == grant)) begin
        bus.M_PADDR  = bus.S_PADDR[i*BUS_WIDTH +: BUS_WIDTH];
        bus.M_PWRITE = bus.S_PWRITE[i];
        bus.M_PWDATA = bus.S_PWDATA[i*BUS_WIDTH +: BUS_WIDTH];
        if (done) begin
          bus.S_PREADY[i] = 1'b1;
          bus.S_PRDATA[i*BUS_WIDTH +: BUS_WIDTH] =
            timeout ? BUS_WIDTH'(ARB_TIMEOUT_DATA) : bus.M_PRDATA;
        end
      end
    end
  end

  assign bus.M_GRANT = grant;

endmodule
